regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (32 registers, 5-bit indices, 32-bit data).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 ctrl_reset  input  1  reset, asynchronous, active-high.
REQ-004 a_req, a_rd, a_data  input  1/5/32  single-cycle writeback requester A: request, destination, value.
REQ-005 a_ready  output  1  A granted this cycle.
REQ-006 b_req, b_rd, b_data  input  1/5/32  multi-cycle writeback requester B: request, destination, value.
REQ-007 b_ready  output  1  B granted this cycle.
REQ-008 issue_valid, issue_rd  input  1/5  multi-cycle op issued to B, with its destination.
REQ-009 issue_ready  output  1  issue accepted this cycle.
REQ-010 ctrl_readRegA, ctrl_readRegB  input  5/5  read indices being decoded.
REQ-011 stall_readA, stall_readB  output  1/1  indexed register has a pending multi-cycle write.
REQ-012 ctrl_writeEnable, ctrl_writeReg, data_writeReg  output  1/5/32  register-file write port.
REQ-013 idle  output  1  no pending multi-cycle writes.

Function
REQ-014 State SHALL be a 32-bit pending vector (bit 0 permanently 0) and a 1-bit round-robin pointer rr (0 favours A, 1 favours B).
REQ-015 Eligibility SHALL be: A eligible = a_req and not (a_rd != 0 and pending[a_rd]); B eligible = b_req.
REQ-016 Grants SHALL be combinational, same cycle: one eligible requester is granted; if both are eligible, the one favoured by rr is granted; a_ready/b_ready are never both 1.
REQ-017 rr SHALL update only on cycles where both are eligible: after granting A, rr=1; after granting B, rr=0.
REQ-018 Write port SHALL carry the granted requester's rd/data; ctrl_writeEnable = (a grant or b grant) and granted rd != 0; with no grant, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
REQ-019 A grant with rd=0 SHALL complete the handshake (ready=1) while suppressing ctrl_writeEnable.
REQ-020 issue_ready SHALL be 1 when issue_rd=0 or pending[issue_rd]=0; the issue is accepted when issue_valid and issue_ready.
REQ-021 On an accepted issue with issue_rd != 0, pending[issue_rd] SHALL be set at the next edge.
REQ-022 On a B grant with b_rd != 0, pending[b_rd] SHALL be cleared at the next edge.
REQ-023 If a set and a clear target the same register in one cycle, set SHALL win.
REQ-024 stall_readA = pending[ctrl_readRegA] and stall_readB = pending[ctrl_readRegB], from registered state only, with no same-cycle bypass of a B grant.
REQ-025 idle SHALL equal NOR of the pending vector.
REQ-026 A requester SHALL hold req/rd/data stable until granted; the block needs no internal data buffering.

Reset
REQ-027 While ctrl_reset=1, independent of clock: pending=0 and rr=0, so idle=1, stall_readA=stall_readB=0, and issue_ready=1.
REQ-028 During reset, grant and write-port outputs SHALL still be evaluated combinationally from inputs against the cleared state.
REQ-029 Reset asserted mid-operation SHALL discard all pending bits; no write is pended or replayed after release.

Verification
REQ-030 Contention: a_req=b_req=1 for 4 cycles from reset, rd 3/4 -> grants A,B,A,B; ctrl_writeReg 3,4,3,4.
REQ-031 Scoreboard: issue rd=7; next cycle a_req rd=7 and ctrl_readRegA=7 -> a_ready=0, stall_readA=1, issue_ready for rd=7 is 0. Then b_req rd=7 data 0xDEADBEEF -> write port shows 7/0xDEADBEEF. Next cycle: a_ready=1, stall_readA=0, idle=1.
REQ-032 Register 0: issue rd=0 -> no pending set, idle stays 1. a_req rd=0 -> a_ready=1 and ctrl_writeEnable=0.
REQ-033 Simultaneous: pending[5]=1; in one cycle b grant rd=5 plus issue rd=5 -> issue_ready=0, so the issue is rejected and pending[5]=0 next cycle. Pending[5]=1, b grant rd=5 and issue rd=9 -> pending = {9} next cycle.
REQ-034 Async reset: with pending {2,6} and rr=1, pulse ctrl_reset between edges -> idle=1 immediately; with both requesting, A is granted first after release.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the register-file writeback arbiter: both writeback
// requesters, the multi-cycle issue port, the decode-stage read probes
// and the register-file write port.
interface regfile_wb_arbiter_if;
    logic        a_req;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        a_ready;

    logic        b_req;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        b_ready;

    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;

    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic        stall_readA;
    logic        stall_readB;

    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;

    logic        idle;

    // Pipeline side: raises requests, issues ops and probes read indices.
    modport master (
        output a_req, a_rd, a_data,
        output b_req, b_rd, b_data,
        output issue_valid, issue_rd,
        output ctrl_readRegA, ctrl_readRegB,
        input  a_ready, b_ready, issue_ready,
        input  stall_readA, stall_readB,
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  idle
    );

    // Arbiter side.
    modport slave (
        input  a_req, a_rd, a_data,
        input  b_req, b_rd, b_data,
        input  issue_valid, issue_rd,
        input  ctrl_readRegA, ctrl_readRegB,
        output a_ready, b_ready, issue_ready,
        output stall_readA, stall_readB,
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output idle
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a 32-entry register file. Requester A is a
// single-cycle unit, requester B a multi-cycle unit whose outstanding
// destinations are tracked in a pending scoreboard. A is blocked from
// writing a register that B still owes; contention is round-robin.
module regfile_wb_arbiter (
    input logic                 clock,
    input logic                 ctrl_reset,
    regfile_wb_arbiter_if.slave bus
);

    logic [31:0] pending_q;
    logic [31:0] pending_d;
    logic        rr_q;
    logic        rr_d;

    logic        a_eligible;
    logic        b_eligible;
    logic        grant_a;
    logic        grant_b;
    logic        issue_accept;

    // Eligibility and same-cycle grant selection; rr breaks ties.
    always_comb begin
        a_eligible = bus.a_req && !((bus.a_rd != 5'd0) && pending_q[bus.a_rd]);
        b_eligible = bus.b_req;
        grant_a    = a_eligible && (!b_eligible || !rr_q);
        grant_b    = b_eligible && (!a_eligible || rr_q);
    end

    // Handshake, write-port mux and scoreboard-derived status outputs.
    always_comb begin
        bus.a_ready          = grant_a;
        bus.b_ready          = grant_b;
        bus.ctrl_writeEnable = 1'b0;
        bus.ctrl_writeReg    = 5'd0;
        bus.data_writeReg    = 32'd0;
        if (grant_a) begin
            bus.ctrl_writeEnable = (bus.a_rd != 5'd0);
            bus.ctrl_writeReg    = bus.a_rd;
            bus.data_writeReg    = bus.a_data;
        end else if (grant_b) begin
            bus.ctrl_writeEnable = (bus.b_rd != 5'd0);
            bus.ctrl_writeReg    = bus.b_rd;
            bus.data_writeReg    = bus.b_data;
        end
        bus.issue_ready = (bus.issue_rd == 5'd0) || !pending_q[bus.issue_rd];
        bus.stall_readA = pending_q[bus.ctrl_readRegA];
        bus.stall_readB = pending_q[bus.ctrl_readRegB];
        bus.idle        = ~|pending_q;
    end

    // Next scoreboard and pointer: clear on B writeback, then set on issue so set wins.
    always_comb begin
        issue_accept = bus.issue_valid && bus.issue_ready;
        pending_d    = pending_q;
        rr_d         = rr_q;
        if (grant_b && (bus.b_rd != 5'd0)) begin
            pending_d[bus.b_rd] = 1'b0;
        end
        if (issue_accept && (bus.issue_rd != 5'd0)) begin
            pending_d[bus.issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
        if (a_eligible && b_eligible) begin
            rr_d = grant_a;
        end
    end

    // State registers; reset drops every outstanding write and favours A.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            pending_q <= 32'd0;
            rr_q      <= 1'b0;
        end else begin
            pending_q <= pending_d;
            rr_q      <= rr_d;
        end
    end

endmodule
